// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus: pipeline trap requests, interrupt lines, CSR access
// port and pipeline control returned by the sequencer.
//   master : pipeline side (drives requests/CSR access, receives control)
//   slave  : trap_sequencer side
interface trap_sequencer_if #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NUM_LOCAL_IRQ = 4
);
  localparam int unsigned LW = (NUM_LOCAL_IRQ == 0) ? 1 : NUM_LOCAL_IRQ;

  logic            exc_valid;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic [XLEN-1:0] int_pc;
  logic            int_window;
  logic            irq_mti;
  logic            irq_msi;
  logic            irq_mei;
  logic [LW-1:0]   irq_local;
  logic            mret;
  logic            csr_en;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            pipe_stall;
  logic            pipe_flush;
  logic            redirect;
  logic [XLEN-1:0] trap_target;

  modport master (
    output exc_valid, exc_cause, exc_pc, exc_tval, int_pc, int_window,
           irq_mti, irq_msi, irq_mei, irq_local, mret,
           csr_en, csr_op, csr_addr, csr_wdata,
    input  csr_rdata, csr_illegal, pipe_stall, pipe_flush, redirect, trap_target
  );

  modport slave (
    input  exc_valid, exc_cause, exc_pc, exc_tval, int_pc, int_window,
           irq_mti, irq_msi, irq_mei, irq_local, mret,
           csr_en, csr_op, csr_addr, csr_wdata,
    output csr_rdata, csr_illegal, pipe_stall, pipe_flush, redirect, trap_target
  );
endinterface

// File: rtl/trap_sequencer.sv
// M-mode trap controller: owns mstatus.MIE/MPIE, mie, mip, mtvec, mepc,
// mcause, mtval; arbitrates exceptions and interrupts, sequences the CSR
// update over IDLE->SAVE->CAUSE->REDIRECT, handles MRET, stalls/flushes the
// pipeline and redirects fetch (direct or vectored).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : trap_sequencer_if.slave (requests, IRQ lines, CSR port, control)
//          csr_rdata/csr_illegal are combinational; stall/flush/redirect/
//          trap_target are registered.
module trap_sequencer #(
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     NUM_LOCAL_IRQ = 4,
  parameter logic [XLEN-1:0] RESET_VEC     = '0
) (
  input  logic            clk,
  input  logic            rst,
  trap_sequencer_if.slave bus
);

  localparam int unsigned CAUSE_W = $clog2(XLEN);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;
  localparam logic [11:0] A_MIP     = 12'h344;

  // Implemented interrupt bits shared by mie and mip.
  function automatic logic [XLEN-1:0] irq_mask();
    logic [XLEN-1:0] m;
    m     = '0;
    m[3]  = 1'b1;
    m[7]  = 1'b1;
    m[11] = 1'b1;
    for (int i = 0; i < int'(NUM_LOCAL_IRQ); i++) m[16+i] = 1'b1;
    return m;
  endfunction
  localparam logic [XLEN-1:0] IRQ_MASK = irq_mask();

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_CAUSE,
    S_REDIRECT,
    S_MRET
  } state_t;

  state_t state, state_n;

  logic               st_mie, st_mpie;
  logic [XLEN-1:0]    mie_q, mip_q, mtvec_q, mepc_q, mcause_q, mtval_q;
  logic               cap_is_int;
  logic [CAUSE_W-1:0] cap_cause;
  logic [XLEN-1:0]    cap_epc, cap_tval;

  logic               stall_q, redirect_q;
  logic [XLEN-1:0]    target_q;
  logic               stall_n, redirect_n;
  logic [XLEN-1:0]    target_n;

  logic [XLEN-1:0]    mip_raw, pend;
  logic               irq_any;
  logic [CAUSE_W-1:0] irq_cause;
  logic               take_exc, take_int, take, do_mret;

  logic [XLEN-1:0]    csr_val, csr_new, mstatus_val, trap_vec;
  logic               csr_hit, csr_wr_req, csr_we;

  // Raw interrupt lines mapped onto the mip bit layout.
  always_comb begin
    mip_raw     = '0;
    mip_raw[3]  = bus.irq_msi;
    mip_raw[7]  = bus.irq_mti;
    mip_raw[11] = bus.irq_mei;
    for (int i = 0; i < int'(NUM_LOCAL_IRQ); i++) mip_raw[16+i] = bus.irq_local[i];
  end

  // Interrupt priority: later assignments win, so locals (lowest index) top.
  always_comb begin
    pend      = mip_q & mie_q;
    irq_any   = |pend;
    irq_cause = '0;
    if (pend[7])  irq_cause = CAUSE_W'(7);
    if (pend[3])  irq_cause = CAUSE_W'(3);
    if (pend[11]) irq_cause = CAUSE_W'(11);
    for (int i = int'(NUM_LOCAL_IRQ) - 1; i >= 0; i--)
      if (pend[16+i]) irq_cause = CAUSE_W'(16 + i);
  end

  assign take_exc = (state == S_IDLE) && bus.exc_valid;
  assign take_int = (state == S_IDLE) && st_mie && irq_any && bus.int_window && !bus.exc_valid;
  assign take     = take_exc || take_int;
  assign do_mret  = (state == S_IDLE) && bus.mret && !bus.exc_valid && !take_int;

  // CSR read mux and op-applied write value.
  always_comb begin
    mstatus_val    = '0;
    mstatus_val[3] = st_mie;
    mstatus_val[7] = st_mpie;
    csr_hit        = 1'b1;
    csr_val        = '0;
    unique case (bus.csr_addr)
      A_MSTATUS: csr_val = mstatus_val;
      A_MIE:     csr_val = mie_q;
      A_MTVEC:   csr_val = mtvec_q;
      A_MEPC:    csr_val = mepc_q;
      A_MCAUSE:  csr_val = mcause_q;
      A_MTVAL:   csr_val = mtval_q;
      A_MIP:     csr_val = mip_q;
      default:   csr_hit = 1'b0;
    endcase
    unique case (bus.csr_op)
      2'b01:   csr_new = bus.csr_wdata;
      2'b10:   csr_new = csr_val | bus.csr_wdata;
      2'b11:   csr_new = csr_val & ~bus.csr_wdata;
      default: csr_new = csr_val;
    endcase
  end

  // Set/clear with a zero operand is a pure read.
  assign csr_wr_req = (bus.csr_op == 2'b01) || (bus.csr_op[1] && (bus.csr_wdata != '0));
  assign csr_we     = bus.csr_en && csr_wr_req && csr_hit && (bus.csr_addr != A_MIP) &&
                      (state == S_IDLE) && !take && !do_mret;

  assign bus.csr_rdata   = bus.csr_en ? csr_val : '0;
  assign bus.csr_illegal = bus.csr_en && (!csr_hit || ((bus.csr_addr == A_MIP) && csr_wr_req));

  // Trap vector; vectored mode only offsets interrupts.
  always_comb begin
    trap_vec = {mtvec_q[XLEN-1:2], 2'b00};
    if ((mtvec_q[1:0] == 2'b01) && cap_is_int)
      trap_vec = trap_vec + (XLEN'(cap_cause) << 2);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next state and next registered outputs.
  always_comb begin
    state_n    = state;
    stall_n    = 1'b0;
    redirect_n = 1'b0;
    target_n   = '0;
    unique case (state)
      S_IDLE: begin
        if (take)         state_n = S_SAVE;
        else if (do_mret) state_n = S_MRET;
      end
      S_SAVE:     state_n = S_CAUSE;
      S_CAUSE:    state_n = S_REDIRECT;
      S_REDIRECT: state_n = S_IDLE;
      S_MRET:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
    unique case (state_n)
      S_SAVE, S_CAUSE: stall_n = 1'b1;
      S_REDIRECT: begin
        redirect_n = 1'b1;
        target_n   = trap_vec;
      end
      S_MRET: begin
        redirect_n = 1'b1;
        target_n   = mepc_q;
      end
      default: ;
    endcase
  end

  // Registered pipeline control.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q    <= 1'b0;
      redirect_q <= 1'b0;
      target_q   <= '0;
    end else begin
      stall_q    <= stall_n;
      redirect_q <= redirect_n;
      target_q   <= target_n;
    end
  end

  assign bus.pipe_stall  = stall_q;
  assign bus.pipe_flush  = redirect_q;
  assign bus.redirect    = redirect_q;
  assign bus.trap_target = target_q;

  // Trap capture, sequenced CSR updates and software CSR writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= RESET_VEC;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      cap_is_int <= 1'b0;
      cap_cause  <= '0;
      cap_epc    <= '0;
      cap_tval   <= '0;
    end else begin
      mip_q <= mip_raw & IRQ_MASK;
      if (take) begin
        cap_is_int <= take_int;
        cap_cause  <= take_exc ? CAUSE_W'(bus.exc_cause) : irq_cause;
        cap_epc    <= take_exc ? bus.exc_pc : bus.int_pc;
        cap_tval   <= take_exc ? bus.exc_tval : '0;
      end
      unique case (state)
        S_SAVE: begin
          mepc_q  <= cap_epc & ~XLEN'(3);
          mtval_q <= cap_tval;
        end
        S_CAUSE: begin
          mcause_q <= {cap_is_int, (XLEN-1)'(cap_cause)};
          st_mpie  <= st_mie;
          st_mie   <= 1'b0;
        end
        S_MRET: begin
          st_mie  <= st_mpie;
          st_mpie <= 1'b1;
        end
        default: ;
      endcase
      if (csr_we) begin
        unique case (bus.csr_addr)
          A_MSTATUS: begin
            st_mie  <= csr_new[3];
            st_mpie <= csr_new[7];
          end
          A_MIE:    mie_q    <= csr_new & IRQ_MASK;
          A_MTVEC:  mtvec_q  <= csr_new;
          A_MEPC:   mepc_q   <= csr_new & ~XLEN'(3);
          A_MCAUSE: mcause_q <= csr_new;
          A_MTVAL:  mtval_q  <= csr_new;
          default: ;
        endcase
      end
    end
  end

endmodule
